// File: rtl/cpu_ctrl_pkg.sv
// Shared constants, state encoding and control-word layout for the hardwired control unit.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [4:0] ALU_ADD = 5'd2;
    localparam logic [4:0] ALU_SUB = 5'd3;
    localparam logic [4:0] ALU_AND = 5'd4;
    localparam logic [4:0] ALU_OR  = 5'd5;
    localparam logic [4:0] ALU_INC = 5'd12;

    typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    typedef struct packed {
        logic       pc_out;
        logic       zlow_out;
        logic       mdr_out;
        logic       ba_out;
        logic       c_out;
        logic       r_out;
        logic       mar_in;
        logic       z_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       r_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       read;
        logic       write;
        logic [4:0] alu;
        logic       done;
    } ctrl_word_t;

    // ALU opcode for the register-register arithmetic/logic group.
    function automatic logic [4:0] alu_for(input logic [4:0] opcode);
        logic [4:0] res;
        res = ALU_ADD;
        case (opcode)
            OP_SUB:  res = ALU_SUB;
            OP_AND:  res = ALU_AND;
            OP_OR:   res = ALU_OR;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational (state, opcode) -> control word decode.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       mem_rdy,
    output ctrl_word_t cw
);

    // Decode the strobes for the current state; anything not set stays 0.
    always_comb begin
        cw = '0;
        unique case (state)
            T0: begin
                cw.pc_out = 1'b1;
                cw.mar_in = 1'b1;
                cw.z_in   = 1'b1;
                cw.alu    = ALU_INC;
            end
            T1: begin
                cw.zlow_out = 1'b1;
                cw.pc_in    = 1'b1;
                cw.read     = 1'b1;
                cw.mdr_in   = 1'b1;
            end
            T2: begin
                cw.mdr_out = 1'b1;
                cw.ir_in   = 1'b1;
            end
            T3: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        cw.grb    = 1'b1;
                        cw.ba_out = 1'b1;
                        cw.y_in   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        cw.grb   = 1'b1;
                        cw.r_out = 1'b1;
                        cw.y_in  = 1'b1;
                    end
                    // nop, halt and undefined opcodes end here.
                    default: cw.done = 1'b1;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                        cw.c_out = 1'b1;
                        cw.z_in  = 1'b1;
                        cw.alu   = ALU_ADD;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        cw.grc   = 1'b1;
                        cw.r_out = 1'b1;
                        cw.z_in  = 1'b1;
                        cw.alu   = alu_for(opcode);
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LD, OP_ST: begin
                        cw.zlow_out = 1'b1;
                        cw.mar_in   = 1'b1;
                    end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        cw.zlow_out = 1'b1;
                        cw.gra      = 1'b1;
                        cw.r_in     = 1'b1;
                        cw.done     = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (opcode)
                    OP_LD: begin
                        cw.read   = 1'b1;
                        cw.mdr_in = 1'b1;
                    end
                    OP_ST: begin
                        cw.gra    = 1'b1;
                        cw.r_out  = 1'b1;
                        cw.mdr_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (opcode)
                    OP_LD: begin
                        cw.mdr_out = 1'b1;
                        cw.gra     = 1'b1;
                        cw.r_in    = 1'b1;
                        cw.done    = 1'b1;
                    end
                    OP_ST: begin
                        cw.write = 1'b1;
                        // Store completes only when memory accepts the write.
                        cw.done  = mem_rdy;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: state register, memory stalls and stop/halt sequencing.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 5,
    parameter int unsigned IR_W  = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [IR_W-1:0] IR,
    input  logic            mem_rdy,
    input  logic            stop,
    output logic            PCout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            BAout,
    output logic            Cout,
    output logic            Rout,
    output logic            MARin,
    output logic            Zin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Rin,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Read,
    output logic            Write,
    output logic [4:0]      ALU_Control,
    output logic            run,
    output logic            instr_done
);

    state_t           state_q, state_d;
    ctrl_word_t       cw;
    logic [OPC_W-1:0] opcode;
    logic             stall;
    logic             unused_ir;

    assign opcode    = IR[IR_W-1 -: OPC_W];
    assign unused_ir = ^IR[IR_W-OPC_W-1:0];

    ctrl_decode u_decode (
        .state   (state_q),
        .opcode  (opcode),
        .mem_rdy (mem_rdy),
        .cw      (cw)
    );

    // A state that strobes memory holds until memory reports ready.
    assign stall = (cw.read | cw.write) & ~mem_rdy;

    // Next state: fetch/execute walk, stalls, and instruction-boundary halt decision.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RST:  state_d = T0;
            HALT: state_d = HALT;
            default: begin
                if (stall) begin
                    state_d = state_q;
                end else if (cw.done) begin
                    state_d = ((opcode == OP_HALT) || stop) ? HALT : T0;
                end else begin
                    case (state_q)
                        T0:      state_d = T1;
                        T1:      state_d = T2;
                        T2:      state_d = T3;
                        T3:      state_d = T4;
                        T4:      state_d = T5;
                        T5:      state_d = T6;
                        T6:      state_d = T7;
                        default: state_d = T0;
                    endcase
                end
            end
        endcase
    end

    // State register; reset drops every output at once since outputs decode from it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    assign PCout       = cw.pc_out;
    assign Zlowout     = cw.zlow_out;
    assign MDRout      = cw.mdr_out;
    assign BAout       = cw.ba_out;
    assign Cout        = cw.c_out;
    assign Rout        = cw.r_out;
    assign MARin       = cw.mar_in;
    assign Zin         = cw.z_in;
    assign PCin        = cw.pc_in;
    assign MDRin       = cw.mdr_in;
    assign IRin        = cw.ir_in;
    assign Yin         = cw.y_in;
    assign Rin         = cw.r_in;
    assign Gra         = cw.gra;
    assign Grb         = cw.grb;
    assign Grc         = cw.grc;
    assign Read        = cw.read;
    assign Write       = cw.write;
    assign ALU_Control = cw.alu;
    assign instr_done  = cw.done;
    assign run         = (state_q != RST) && (state_q != HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: table-driven instruction model with random stalls and IR fields.
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] IR;
    logic        mem_rdy;
    logic        stop;
    logic PCout, Zlowout, MDRout, BAout, Cout, Rout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
    logic Gra, Grb, Grc, Read, Write, run, instr_done;
    logic [4:0] ALU_Control;

    control_sequencer dut (
        .clk         (clk),
        .clr         (clr),
        .IR          (IR),
        .mem_rdy     (mem_rdy),
        .stop        (stop),
        .PCout       (PCout),
        .Zlowout     (Zlowout),
        .MDRout      (MDRout),
        .BAout       (BAout),
        .Cout        (Cout),
        .Rout        (Rout),
        .MARin       (MARin),
        .Zin         (Zin),
        .PCin        (PCin),
        .MDRin       (MDRin),
        .IRin        (IRin),
        .Yin         (Yin),
        .Rin         (Rin),
        .Gra         (Gra),
        .Grb         (Grb),
        .Grc         (Grc),
        .Read        (Read),
        .Write       (Write),
        .ALU_Control (ALU_Control),
        .run         (run),
        .instr_done  (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: 18 strobes, ALU_Control, run, instr_done.
    logic [24:0] obs;
    assign obs = {PCout, Zlowout, MDRout, BAout, Cout, Rout, MARin, Zin, PCin, MDRin, IRin,
                  Yin, Rin, Gra, Grb, Grc, Read, Write, ALU_Control, run, instr_done};

    localparam logic [17:0] S_PCOUT = 18'h20000;
    localparam logic [17:0] S_ZLOW  = 18'h10000;
    localparam logic [17:0] S_MDRO  = 18'h08000;
    localparam logic [17:0] S_BAOUT = 18'h04000;
    localparam logic [17:0] S_COUT  = 18'h02000;
    localparam logic [17:0] S_ROUT  = 18'h01000;
    localparam logic [17:0] S_MARIN = 18'h00800;
    localparam logic [17:0] S_ZIN   = 18'h00400;
    localparam logic [17:0] S_PCIN  = 18'h00200;
    localparam logic [17:0] S_MDRIN = 18'h00100;
    localparam logic [17:0] S_IRIN  = 18'h00080;
    localparam logic [17:0] S_YIN   = 18'h00040;
    localparam logic [17:0] S_RIN   = 18'h00020;
    localparam logic [17:0] S_GRA   = 18'h00010;
    localparam logic [17:0] S_GRB   = 18'h00008;
    localparam logic [17:0] S_GRC   = 18'h00004;
    localparam logic [17:0] S_READ  = 18'h00002;
    localparam logic [17:0] S_WRITE = 18'h00001;

    typedef struct {
        logic [17:0] s;
        logic [4:0]  alu;
        bit          mem;
        bit          last;
    } step_t;

    step_t prog[$];
    int    n_total = 0;
    int    n_bad   = 0;

    task automatic check_eq(input string tag, input logic [24:0] got, input logic [24:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic step_t mk(input logic [17:0] s, input logic [4:0] alu, input bit mem,
                                 input bit last);
        step_t st;
        st.s = s; st.alu = alu; st.mem = mem; st.last = last;
        return st;
    endfunction

    // Instruction behaviour as a list of register-transfer steps.
    task automatic build_prog(input logic [4:0] op);
        prog.delete();
        prog.push_back(mk(S_PCOUT | S_MARIN | S_ZIN, 5'd12, 0, 0));
        prog.push_back(mk(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 5'd0, 1, 0));
        prog.push_back(mk(S_MDRO | S_IRIN, 5'd0, 0, 0));
        case (op)
            5'd0, 5'd1, 5'd2: begin
                prog.push_back(mk(S_GRB | S_BAOUT | S_YIN, 5'd0, 0, 0));
                prog.push_back(mk(S_COUT | S_ZIN, 5'd2, 0, 0));
                if (op == 5'd1) begin
                    prog.push_back(mk(S_ZLOW | S_GRA | S_RIN, 5'd0, 0, 1));
                end else begin
                    prog.push_back(mk(S_ZLOW | S_MARIN, 5'd0, 0, 0));
                    if (op == 5'd0) begin
                        prog.push_back(mk(S_READ | S_MDRIN, 5'd0, 1, 0));
                        prog.push_back(mk(S_MDRO | S_GRA | S_RIN, 5'd0, 0, 1));
                    end else begin
                        prog.push_back(mk(S_GRA | S_ROUT | S_MDRIN, 5'd0, 0, 0));
                        prog.push_back(mk(S_WRITE, 5'd0, 1, 1));
                    end
                end
            end
            5'd3, 5'd4, 5'd5, 5'd6: begin
                prog.push_back(mk(S_GRB | S_ROUT | S_YIN, 5'd0, 0, 0));
                prog.push_back(mk(S_GRC | S_ROUT | S_ZIN, op - 5'd1, 0, 0));
                prog.push_back(mk(S_ZLOW | S_GRA | S_RIN, 5'd0, 0, 1));
            end
            5'd12: begin
                prog.push_back(mk(S_GRB | S_ROUT | S_YIN, 5'd0, 0, 0));
                prog.push_back(mk(S_COUT | S_ZIN, 5'd2, 0, 0));
                prog.push_back(mk(S_ZLOW | S_GRA | S_RIN, 5'd0, 0, 1));
            end
            default: prog.push_back(mk(18'd0, 5'd0, 0, 1));
        endcase
    endtask

    // Entered just after the edge into T0; leaves just after the edge into the next state.
    task automatic run_instr(input logic [31:0] ir, input int fstall, input int xstall,
                             input int stop_step, input int abort_step,
                             output bit halted, output bit aborted);
        int  k;
        int  nst;
        bit  more;
        build_prog(ir[31:27]);
        IR      = ir;
        halted  = 0;
        aborted = 0;
        for (int i = 0; i < prog.size(); i++) begin
            k   = 0;
            nst = (i < 3) ? fstall : xstall;
            do begin
                stop = (stop_step >= 0) && (i >= stop_step);
                if (prog[i].mem) mem_rdy = (k >= nst);
                else mem_rdy = 1'($urandom);
                @(negedge clk);
                check_eq($sformatf("op%0d_step%0d", ir[31:27], i), obs,
                         {prog[i].s, prog[i].alu, 1'b1,
                          1'(prog[i].last && (!prog[i].mem || mem_rdy))});
                if (i == abort_step) begin
                    #2 clr = 1'b0;
                    #1 check_eq("reset_async", obs, 25'd0);
                    @(negedge clk);
                    check_eq("reset_hold", obs, 25'd0);
                    #1 clr = 1'b1;
                    stop = 1'b0;
                    @(posedge clk);
                    #1;
                    aborted = 1;
                    return;
                end
                more = prog[i].mem && !mem_rdy;
                if (!more && prog[i].last) halted = (ir[31:27] == 5'd27) || stop;
                @(posedge clk);
                #1;
                k++;
            end while (more);
        end
        stop = 1'b0;
    endtask

    task automatic check_halt(input int n);
        for (int i = 0; i < n; i++) begin
            mem_rdy = 1'($urandom);
            stop    = 1'($urandom);
            @(negedge clk);
            check_eq("halt_idle", obs, 25'd0);
            @(posedge clk);
            #1;
        end
        stop = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #1 check_eq("reset", obs, 25'd0);
        @(negedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [4:0] op_tbl [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd26};

    initial begin
        bit         h;
        bit         a;
        logic [4:0] op;
        clr = 1'b0; IR = 32'd0; mem_rdy = 1'b0; stop = 1'b0;
        #3 check_eq("reset_init", obs, 25'd0);
        @(negedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1;

        run_instr(32'h08080045, 0, 0, -1, -1, h, a);
        run_instr(32'h00800063, 0, 3, -1, -1, h, a);
        run_instr(32'h10000000, 0, 2, -1, -1, h, a);
        run_instr(32'h18000000, 0, 0, -1, -1, h, a);
        run_instr(32'hF8000000, 0, 0, -1, -1, h, a);
        run_instr(32'hD8000000, 1, 0, -1, -1, h, a);
        if (h) check_halt(20);
        do_reset();

        // Reset asserted during T4 of a load, then a clean restart.
        run_instr(32'h00800063, 0, 0, -1, 4, h, a);
        run_instr(32'h08080045, 0, 0, -1, -1, h, a);

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 9) == 9) ? 5'($urandom) : op_tbl[$urandom_range(0, 8)];
            run_instr({op, 27'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 3),
                      -1, -1, h, a);
            if (h) begin
                check_halt(3);
                do_reset();
            end
        end

        // stop raised in T4 of an add: the add finishes, then the unit halts.
        run_instr({5'd3, 27'($urandom)}, 0, 0, 4, -1, h, a);
        if (h) check_halt(5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "timeout");
    end

endmodule
